hit_sram_circular_buffer: RTL and testbench
===========================================

HIT_SRAM_CIRCULAR_BUFFER -- requirements
Module: hit_sram_circular_buffer

Interface
REQ-001 Parameter: AW, default 9, address width.
REQ-002 Parameter: DEPTH, default 512 (2**AW), number of hit-flag entries.
REQ-003 Port: clk  input  1  40 MHz clock; all state changes on rising edge.
REQ-004 Port: rstn  input  1  reset, asynchronous, active-low.
REQ-005 Port: dis  input  1  disable; when 1, no writes, no reads, all outputs hold.
REQ-006 Port: hit  input  1  hit flag to store at wrAddr this cycle.
REQ-007 Port: wrAddr  input  AW  write address (free-running circular pointer supplied externally).
REQ-008 Port: rden  input  1  read enable (synchronized L1A).
REQ-009 Port: rdAddr  input  AW  read address.
REQ-010 Port: outHit  output  1  voted hit flag of last read.
REQ-011 Port: E1A  output  1  single-copy disagreement detected on last read.
REQ-012 Port: E2A  output  1  reserved double-error flag.

Function
REQ-013 Each entry SHALL hold three redundant copies of the hit bit.
REQ-014 On rising clk with dis=0, all three copies at wrAddr SHALL be written with hit, every cycle (hit=0 writes clear stale entries).
REQ-015 On rising clk with dis=0 and rden=1, outHit SHALL register the 2-of-3 majority of the copies at rdAddr; latency one cycle.
REQ-016 On the same edge, E1A SHALL register 1 if the three copies at rdAddr are not all equal, else 0.
REQ-017 outHit and E1A SHALL hold their values when rden=0 or dis=1.
REQ-018 E2A SHALL be constant 0 (triple redundancy of one bit cannot flag double errors).
REQ-019 Read and write to the same address on the same edge SHALL return the old (pre-write) content.
REQ-020 Addresses SHALL wrap modulo DEPTH with no special handling; any 9-bit value is valid.
REQ-021 dis=1 SHALL freeze memory contents and outputs regardless of hit, rden, addresses.
REQ-022 Per-copy corruption SHALL be injectable by the bench only via hierarchical force; no functional port exists for it.

Reset
REQ-023 rstn=0 SHALL asynchronously clear all memory copies, outHit, E1A to 0.
REQ-024 Reset SHALL take precedence over dis, write and read in the same cycle; first write/read occurs on first rising edge after rstn release.
REQ-025 Reset asserted mid-operation SHALL discard all stored hits; subsequent reads of unwritten addresses return outHit=0, E1A=0.

Structure
REQ-026 A shared package SHALL hold AW, DEPTH defaults and the majority/disagree function prototypes.
REQ-027 One sub-module, tmr_vote (3 inputs -> majority, mismatch), SHALL be instantiated once on the read path.
REQ-028 Memory SHALL be flip-flop based (three DEPTH-bit arrays), no clock gating inside the block.

Verification
REQ-029 Reset, write hit=1 at addr 5, next cycle rden=1 rdAddr=5 -> outHit=1, E1A=0 one cycle later.
REQ-030 Write hit=1 at 5, later write hit=0 at 5, read 5 -> outHit=0.
REQ-031 Force copy 1 of entry 7 to 0 after writing hit=1 -> read 7 gives outHit=1, E1A=1; E2A=0 always.
REQ-032 Same-edge write hit=1 and read at addr 9 (previously 0) -> outHit=0; next read -> 1.
REQ-033 dis=1 with hit=1 at addr 3 and rden=1 -> memory and outputs unchanged; after dis=0 read 3 -> 0.
REQ-034 Write addr 511 then 0 (wrap), read both -> correct values; assert rstn mid-run -> outputs 0 immediately.

Source files
------------

// File: rtl/hit_sram_circular_buffer_pkg.sv
// Shared sizing defaults and triple-redundancy helpers for the hit-flag ring.
`timescale 1ns/1ps
package hit_sram_circular_buffer_pkg;

  localparam int AW_DEF    = 9;
  localparam int DEPTH_DEF = 1 << AW_DEF;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Any single copy differing from the others shows up as a pairwise XOR.
  function automatic logic disagree3(input logic a, input logic b, input logic c);
    return (a ^ b) | (a ^ c);
  endfunction

endpackage

// File: rtl/hit_sram_circular_buffer_tmr_vote.sv
// Combinational 2-of-3 voter with copy-mismatch flag; zero latency, no flow control.
`timescale 1ns/1ps
module tmr_vote
  import hit_sram_circular_buffer_pkg::*;
(
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic maj_o,
  output logic mis_o
);

  assign maj_o = maj3(a_i, b_i, c_i);
  assign mis_o = disagree3(a_i, b_i, c_i);

endmodule

// File: rtl/hit_sram_circular_buffer.sv
// Triple-redundant flop-based hit-flag ring; write every cycle, voted read registered after one cycle.
// dis freezes memory and outputs; reads see pre-write content on a same-address edge.
`timescale 1ns/1ps
module hit_sram_circular_buffer
  import hit_sram_circular_buffer_pkg::*;
#(
  parameter int AW    = AW_DEF,
  parameter int DEPTH = DEPTH_DEF
)
(
  input  logic          clk,
  input  logic          rstn,
  input  logic          dis,
  input  logic          hit,
  input  logic [AW-1:0] wrAddr,
  input  logic          rden,
  input  logic [AW-1:0] rdAddr,
  output logic          outHit,
  output logic          E1A,
  output logic          E2A
);

  logic [DEPTH-1:0] mem0_q, mem0_d;
  logic [DEPTH-1:0] mem1_q, mem1_d;
  logic [DEPTH-1:0] mem2_q, mem2_d;
  logic             out_hit_q, out_hit_d;
  logic             e1a_q, e1a_d;
  logic             vote_maj, vote_mis;
  logic             rd_fire;

  // Voter reads the registered copies, so a same-edge write is not yet visible.
  tmr_vote u_vote (
    .a_i   (mem0_q[rdAddr]),
    .b_i   (mem1_q[rdAddr]),
    .c_i   (mem2_q[rdAddr]),
    .maj_o (vote_maj),
    .mis_o (vote_mis)
  );

  assign rd_fire = ~dis & rden;

  always_comb begin
    mem0_d    = mem0_q;
    mem1_d    = mem1_q;
    mem2_d    = mem2_q;
    out_hit_d = out_hit_q;
    e1a_d     = e1a_q;
    if (!dis) begin
      mem0_d[wrAddr] = hit;
      mem1_d[wrAddr] = hit;
      mem2_d[wrAddr] = hit;
    end
    if (rd_fire) begin
      out_hit_d = vote_maj;
      e1a_d     = vote_mis;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem0_q    <= '0;
      mem1_q    <= '0;
      mem2_q    <= '0;
      out_hit_q <= 1'b0;
      e1a_q     <= 1'b0;
    end else begin
      mem0_q    <= mem0_d;
      mem1_q    <= mem1_d;
      mem2_q    <= mem2_d;
      out_hit_q <= out_hit_d;
      e1a_q     <= e1a_d;
    end
  end

  assign outHit = out_hit_q;
  assign E1A    = e1a_q;
  // A single bit in triplicate cannot distinguish a double upset from a valid value.
  assign E2A    = 1'b0;

endmodule

// File: tb/tb_hit_sram_circular_buffer.sv
// Randomized and directed bench for the redundant hit-flag ring against a flat bit-array model.
`timescale 1ns/1ps
module tb_hit_sram_circular_buffer;

  localparam int AW    = 9;
  localparam int DEPTH = 512;

  logic          clk;
  logic          rstn;
  logic          dis;
  logic          hit;
  logic [AW-1:0] wrAddr;
  logic          rden;
  logic [AW-1:0] rdAddr;
  logic          outHit;
  logic          E1A;
  logic          E2A;

  hit_sram_circular_buffer #(.AW(AW), .DEPTH(DEPTH)) dut (
    .clk    (clk),
    .rstn   (rstn),
    .dis    (dis),
    .hit    (hit),
    .wrAddr (wrAddr),
    .rden   (rden),
    .rdAddr (rdAddr),
    .outHit (outHit),
    .E1A    (E1A),
    .E2A    (E2A)
  );

  initial clk = 1'b0;
  always #12.5 clk = ~clk;

  // Reference: one logical bit per address plus the last-read results.
  bit mdl [DEPTH];
  bit exp_hit;
  bit exp_e1a;
  int n_chk;
  int n_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic mdl_reset();
    for (int i = 0; i < DEPTH; i++) mdl[i] = 1'b0;
    exp_hit = 1'b0;
    exp_e1a = 1'b0;
  endtask

  task automatic check_outs(input string tag);
    chk({tag, ".outHit"}, {31'd0, outHit}, {31'd0, exp_hit});
    chk({tag, ".E1A"},    {31'd0, E1A},    {31'd0, exp_e1a});
    chk({tag, ".E2A"},    {31'd0, E2A},    32'd0);
  endtask

  // One clock: apply inputs, advance the model at the edge, check 1 ns later.
  task automatic cyc(input string tag, input logic d, input logic h, input logic [AW-1:0] wa,
                     input logic re, input logic [AW-1:0] ra);
    dis = d; hit = h; wrAddr = wa; rden = re; rdAddr = ra;
    @(posedge clk);
    if (!d) begin
      if (re) begin
        exp_hit = mdl[ra];
        exp_e1a = 1'b0;
      end
      mdl[wa] = h;
    end
    #1;
    check_outs(tag);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    #1;
    mdl_reset();
    check_outs("reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  logic [DEPTH-1:0] forced_v;

  initial begin
    n_chk = 0;
    n_err = 0;
    dis = 1'b0; hit = 1'b0; wrAddr = '0; rden = 1'b0; rdAddr = '0;
    rstn = 1'b0;
    mdl_reset();
    do_reset();

    // Basic write then read at 5, then overwrite with 0.
    cyc("w5",      0, 1, 9'd5,   0, 9'd0);
    cyc("r5",      0, 0, 9'd40,  1, 9'd5);
    chk("r5.direct", {31'd0, outHit}, 32'd1);
    cyc("w5clr",   0, 0, 9'd5,   0, 9'd0);
    cyc("r5clr",   0, 0, 9'd41,  1, 9'd5);
    chk("r5clr.direct", {31'd0, outHit}, 32'd0);

    // Same-edge read/write at 9 sees old content first.
    cyc("rw9",     0, 1, 9'd9,   1, 9'd9);
    chk("rw9.direct", {31'd0, outHit}, 32'd0);
    cyc("r9",      0, 0, 9'd42,  1, 9'd9);
    chk("r9.direct", {31'd0, outHit}, 32'd1);

    // Disable freezes memory and the held outHit=1.
    cyc("dis3",    1, 1, 9'd3,   1, 9'd3);
    chk("dis3.hold", {31'd0, outHit}, 32'd1);
    cyc("dis3b",   1, 1, 9'd3,   1, 9'd5);
    cyc("r3",      0, 0, 9'd43,  1, 9'd3);
    chk("r3.direct", {31'd0, outHit}, 32'd0);

    // Address wrap: top and bottom entries.
    cyc("w511",    0, 1, 9'd511, 0, 9'd0);
    cyc("w0",      0, 1, 9'd0,   0, 9'd0);
    cyc("r511",    0, 0, 9'd300, 1, 9'd511);
    cyc("r0",      0, 0, 9'd301, 1, 9'd0);
    chk("r0.direct", {31'd0, outHit}, 32'd1);
    cyc("w0clr",   0, 0, 9'd0,   1, 9'd510);
    cyc("r0clr",   0, 0, 9'd302, 1, 9'd0);

    // Single-copy upset on entry 7: vote still 1, mismatch flagged.
    cyc("w7",      0, 1, 9'd7,   0, 9'd0);
    forced_v = dut.mem1_q;
    forced_v[7] = 1'b0;
    force dut.mem1_q = forced_v;
    dis = 0; hit = 0; wrAddr = 9'd200; rden = 1; rdAddr = 9'd7;
    @(posedge clk);
    #1;
    chk("seu7.outHit", {31'd0, outHit}, 32'd1);
    chk("seu7.E1A",    {31'd0, E1A},    32'd1);
    chk("seu7.E2A",    {31'd0, E2A},    32'd0);
    release dut.mem1_q;
    rden = 0;

    // Mid-run reset with outHit=1 held: outputs clear asynchronously, memory discarded.
    mdl_reset();
    do_reset();
    cyc("w12",     0, 1, 9'd12,  0, 9'd0);
    cyc("r12",     0, 0, 9'd13,  1, 9'd12);
    chk("r12.direct", {31'd0, outHit}, 32'd1);
    #5;
    rstn = 1'b0;
    #1;
    chk("arst.outHit", {31'd0, outHit}, 32'd0);
    chk("arst.E1A",    {31'd0, E1A},    32'd0);
    mdl_reset();
    @(posedge clk);
    #1;
    rstn = 1'b1;
    cyc("r12post", 0, 0, 9'd100, 1, 9'd12);
    chk("r12post.direct", {31'd0, outHit}, 32'd0);

    // Randomized traffic, mostly in a small window so reads hit written entries.
    for (int i = 0; i < 3000; i++) begin
      logic          d, h, re;
      logic [AW-1:0] wa, ra;
      d  = ($urandom_range(0, 9) == 0);
      h  = $urandom_range(0, 1) != 0;
      re = $urandom_range(0, 2) != 0;
      if ($urandom_range(0, 7) == 0) begin
        wa = AW'($urandom);
        ra = AW'($urandom);
      end else begin
        wa = AW'($urandom_range(0, 15)) - AW'(4);
        ra = AW'($urandom_range(0, 15)) - AW'(4);
      end
      cyc("rand", d, h, wa, re, ra);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
